seg7_reader: RTL and testbench
==============================

# seg7_reader

Receive-side counterpart of the 7-segment message decoder. Samples a 7-bit segment bus, filters glitches by requiring a stable pattern, encodes each accepted pattern back to a 4-bit symbol code, and tracks progress through the fixed 10-symbol message "UABC-ELECT". It sits on the loopback/verification path behind the display driver, or on an input header monitoring an external display.

## Interface
Parameters:
- STABLE_CYCLES, default 4: consecutive sampling edges a pattern must hold before acceptance; legal range 1..255.

Ports:
- clk  in  1  system clock; the only clock.
- rst_n  in  1  synchronous reset, active-low.
- ena  in  1  clock enable; low freezes all state, no pulses.
- segments  in  7  segment pattern, bit 0 = segment 1 (top) ... bit 6 = segment 7 (middle).
- sym_valid  out  1  one-cycle pulse, new symbol accepted.
- sym_code  out  4  code of the last accepted symbol; held between pulses.
- seq_pos  out  4  next expected message position, 0..9.
- seq_error  out  1  sticky; set on any sequence mismatch; cleared only by reset.
- msg_done  out  1  one-cycle pulse when position 9 (T) is accepted in sequence.

## Operation
- Symbol encoding (segments -> code): 0111110 U->0, 1110111 A->1, 1111100 B->2, 0111001 C->3, 1000000 '-'->4, 1111001 E->5, 0111000 L->6, 0110001 T->9, 0000000 blank->15, any other pattern->14 (invalid).
- Expected message by position 0..9: U A B C - E L E C T; codes 0,1,2,3,4,5,6,5,3,9.
- Stability filter: a candidate register plus a saturating 8-bit counter. A sampled value that differs from the candidate reloads the candidate and sets count=1. An equal value increments the counter, saturating at STABLE_CYCLES.
- Acceptance: on the edge where count first reaches STABLE_CYCLES and the candidate differs from the last accepted pattern. That edge updates the last accepted pattern and sym_code, and pulses sym_valid. Re-display of the same symbol is accepted only after an intervening different stable pattern, for example blank.
- Sequence checker FSM, states SYNC and LOCK:
  - SYNC: ignores everything except U. U -> LOCK, seq_pos=1.
  - LOCK: an accepted code equal to expected(seq_pos) advances seq_pos. At position 9 it wraps to 0, pulses msg_done and stays in LOCK.
  - LOCK, blank (15): ignored in both states; no position change.
  - LOCK, mismatch (including 14): sets seq_error. If the mismatching symbol is U: seq_pos=1, stay LOCK. Otherwise: -> SYNC, seq_pos=0.
- ena low: the candidate, counter, FSM and outputs all hold; sym_valid and msg_done are 0.

## Timing
- Reset values: sym_valid=0, sym_code=15, seq_pos=0, seq_error=0, msg_done=0, FSM=SYNC. Last accepted pattern = blank, candidate = blank, count=STABLE_CYCLES. As a result, a blank held through and after reset is never re-accepted.
- Latency: with edge k the first to sample a new value held steadily, sym_valid is high in the cycle after edge k+STABLE_CYCLES-1. STABLE_CYCLES=1 accepts at edge k.
- msg_done, seq_pos and seq_error update on the same edge as the sym_valid that caused them, all registered.
- A glitch shorter than STABLE_CYCLES edges restarts the count; nothing is accepted.
- Reset asserted mid-message: all state returns to reset values at the next edge, regardless of ena.

## Configuration
- SEG7_READER_SEQCHK_EN defined: the sequence checker FSM is present as described.
- Not defined: the FSM is removed; seq_pos=0, seq_error=0, msg_done=0 constantly. The filter and encoder are unchanged.

## Structure
- Package seg7_pkg holds:
  - the 7-bit pattern constants;
  - the symbol code constants (including CODE_BLANK=15, CODE_INVALID=14);
  - MSG_LEN=10;
  - the expected-code lookup function;
  - the pattern-to-code encode function.
- Sub-module seg7_stable_filter (candidate register, counter, acceptance strobe), parameterised by STABLE_CYCLES.

## Test plan
- Full message: drive U A B C - E L E C T, each held 6 cycles, STABLE_CYCLES=4. Expect 10 sym_valid pulses with codes 0,1,2,3,4,5,6,5,3,9. Expect msg_done on the 10th pulse, seq_pos=0 after it, seq_error=0.
- Glitch rejection: with U stable, drive A for 3 cycles then back to U. Expect no sym_valid. Then hold A for 4 cycles: sym_valid after edge k+3.
- Mismatch recovery: drive U A C. Expect seq_error=1 and seq_pos=0/SYNC after C. Then U: seq_pos=1, seq_error stays 1.
- Invalid and blank: pattern 1010101 gives code 14; in LOCK it sets seq_error. Blank between two E's gives three sym_valid pulses (5,15,5) with seq_pos unaffected by the blank.
- ena and reset: lower ena mid-count for 5 cycles and expect no acceptance or state change. Pulse rst_n low for one edge at seq_pos=6 and expect all outputs at reset values.
- Macro off: the full-message stimulus gives identical sym_valid and sym_code, with seq_pos, seq_error and msg_done constantly 0.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants and helpers for the 7-segment receive path: segment patterns,
// symbol codes, the expected message and the pattern-to-code encoder.
package seg7_pkg;

  localparam int unsigned SEG_W   = 7;
  localparam int unsigned CODE_W  = 4;
  localparam int unsigned POS_W   = 4;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned MSG_LEN = 10;

  typedef logic [SEG_W-1:0]  seg_t;
  typedef logic [CODE_W-1:0] code_t;
  typedef logic [POS_W-1:0]  pos_t;

  typedef enum logic {
    ST_SYNC = 1'b0,
    ST_LOCK = 1'b1
  } seq_state_e;

  // Bit 0 is segment 1 (top), bit 6 is segment 7 (middle).
  localparam seg_t PAT_U     = 7'b0111110;
  localparam seg_t PAT_A     = 7'b1110111;
  localparam seg_t PAT_B     = 7'b1111100;
  localparam seg_t PAT_C     = 7'b0111001;
  localparam seg_t PAT_DASH  = 7'b1000000;
  localparam seg_t PAT_E     = 7'b1111001;
  localparam seg_t PAT_L     = 7'b0111000;
  localparam seg_t PAT_T     = 7'b0110001;
  localparam seg_t PAT_BLANK = 7'b0000000;

  localparam code_t CODE_U       = 4'd0;
  localparam code_t CODE_A       = 4'd1;
  localparam code_t CODE_B       = 4'd2;
  localparam code_t CODE_C       = 4'd3;
  localparam code_t CODE_DASH    = 4'd4;
  localparam code_t CODE_E       = 4'd5;
  localparam code_t CODE_L       = 4'd6;
  localparam code_t CODE_T       = 4'd9;
  localparam code_t CODE_INVALID = 4'd14;
  localparam code_t CODE_BLANK   = 4'd15;

  function automatic code_t encode(input seg_t pat);
    code_t code;
    case (pat)
      PAT_U:     code = CODE_U;
      PAT_A:     code = CODE_A;
      PAT_B:     code = CODE_B;
      PAT_C:     code = CODE_C;
      PAT_DASH:  code = CODE_DASH;
      PAT_E:     code = CODE_E;
      PAT_L:     code = CODE_L;
      PAT_T:     code = CODE_T;
      PAT_BLANK: code = CODE_BLANK;
      default:   code = CODE_INVALID;
    endcase
    return code;
  endfunction

  // Message "UABC-ELECT" by position.
  function automatic code_t expected_code(input pos_t pos);
    code_t code;
    case (pos)
      4'd0:    code = CODE_U;
      4'd1:    code = CODE_A;
      4'd2:    code = CODE_B;
      4'd3:    code = CODE_C;
      4'd4:    code = CODE_DASH;
      4'd5:    code = CODE_E;
      4'd6:    code = CODE_L;
      4'd7:    code = CODE_E;
      4'd8:    code = CODE_C;
      4'd9:    code = CODE_T;
      default: code = CODE_INVALID;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/seg7_stable_filter.sv
// Glitch filter: a pattern must hold STABLE_CYCLES sampling edges and differ from
// the last accepted pattern before it is accepted.
module seg7_stable_filter
  import seg7_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [SEG_W-1:0] segments,
  output logic             accept_c,
  output logic [SEG_W-1:0] pattern_c
);

  localparam logic [CNT_W-1:0] STABLE    = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] STABLE_M1 = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  seg_t             cand_q, cand_d;
  seg_t             last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             reached;

  always_comb begin
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    reached  = 1'b0;
    accept_c = 1'b0;
    if (ena) begin
      if (segments != cand_q) begin
        cand_d  = segments;
        cnt_d   = CNT_ONE;
        reached = (STABLE == CNT_ONE);
      end else if (cnt_q != STABLE) begin
        cnt_d   = cnt_q + CNT_ONE;
        reached = (cnt_q == STABLE_M1);
      end
      // Same symbol is only re-accepted after a different stable pattern.
      if (reached && (cand_d != last_q)) begin
        accept_c = 1'b1;
        last_d   = cand_d;
      end
    end
  end

  assign pattern_c = cand_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cand_q <= PAT_BLANK;
      cnt_q  <= STABLE;
      last_q <= PAT_BLANK;
    end else begin
      cand_q <= cand_d;
      cnt_q  <= cnt_d;
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/seg7_reader.sv
// 7-segment reader: filters and encodes the segment bus and tracks "UABC-ELECT".
// The sequence checker is present only when SEG7_READER_SEQCHK_EN is defined.
module seg7_reader
  import seg7_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic [SEG_W-1:0]  segments,
  output logic              sym_valid,
  output logic [CODE_W-1:0] sym_code,
  output logic [POS_W-1:0]  seq_pos,
  output logic              seq_error,
  output logic              msg_done
);

  logic  accept_c;
  seg_t  pattern_c;
  code_t code_c;

  seg7_stable_filter #(
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_filter (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
    .segments (segments),
    .accept_c (accept_c),
    .pattern_c(pattern_c)
  );

  assign code_c = encode(pattern_c);

  logic  sym_valid_q, sym_valid_d;
  code_t sym_code_q, sym_code_d;

  always_comb begin
    sym_valid_d = accept_c;
    sym_code_d  = accept_c ? code_c : sym_code_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sym_valid_q <= 1'b0;
      sym_code_q  <= CODE_BLANK;
    end else begin
      sym_valid_q <= sym_valid_d;
      sym_code_q  <= sym_code_d;
    end
  end

  assign sym_valid = sym_valid_q;
  assign sym_code  = sym_code_q;

`ifdef SEG7_READER_SEQCHK_EN
  localparam pos_t LAST_POS = POS_W'(MSG_LEN - 1);

  seq_state_e state_q, state_d;
  pos_t       seq_pos_q, seq_pos_d;
  logic       seq_error_q, seq_error_d;
  logic       msg_done_q, msg_done_d;
  logic       match_c;

  assign match_c = (code_c == expected_code(seq_pos_q));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_SYNC;
      seq_pos_q   <= '0;
      seq_error_q <= 1'b0;
      msg_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      seq_pos_q   <= seq_pos_d;
      seq_error_q <= seq_error_d;
      msg_done_q  <= msg_done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (accept_c) begin
      case (state_q)
        ST_SYNC: if (code_c == CODE_U) state_d = ST_LOCK;
        ST_LOCK: begin
          // A mismatching U resynchronises in place; any other mismatch drops lock.
          if ((code_c != CODE_BLANK) && !match_c && (code_c != CODE_U)) state_d = ST_SYNC;
        end
        default: state_d = ST_SYNC;
      endcase
    end
  end

  always_comb begin
    seq_pos_d   = seq_pos_q;
    seq_error_d = seq_error_q;
    msg_done_d  = 1'b0;
    if (accept_c) begin
      case (state_q)
        ST_SYNC: if (code_c == CODE_U) seq_pos_d = POS_W'(1);
        ST_LOCK: begin
          if (code_c == CODE_BLANK) begin
            seq_pos_d = seq_pos_q;
          end else if (match_c) begin
            if (seq_pos_q == LAST_POS) begin
              seq_pos_d  = '0;
              msg_done_d = 1'b1;
            end else begin
              seq_pos_d = seq_pos_q + POS_W'(1);
            end
          end else begin
            seq_error_d = 1'b1;
            seq_pos_d   = (code_c == CODE_U) ? POS_W'(1) : '0;
          end
        end
        default: seq_pos_d = '0;
      endcase
    end
  end

  assign seq_pos   = seq_pos_q;
  assign seq_error = seq_error_q;
  assign msg_done  = msg_done_q;
`else
  assign seq_pos   = '0;
  assign seq_error = 1'b0;
  assign msg_done  = 1'b0;
`endif

endmodule

// File: tb/tb_seg7_reader.sv
// Bench for seg7_reader: STABLE_CYCLES=4 and =1 instances against a run-length model,
// plus directed message, glitch, mismatch, enable and reset sequences.
module tb_seg7_reader;

`ifdef SEG7_READER_SEQCHK_EN
  localparam bit SEQ_EN = 1'b1;
`else
  localparam bit SEQ_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n, ena;
  logic [6:0] segments;

  logic       sv4, err4, done4, sv1, err1, done1;
  logic [3:0] code4, pos4, code1, pos1;

  always #5 clk = ~clk;

  seg7_reader #(.STABLE_CYCLES(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .segments(segments),
    .sym_valid(sv4), .sym_code(code4), .seq_pos(pos4), .seq_error(err4), .msg_done(done4)
  );

  seg7_reader #(.STABLE_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .segments(segments),
    .sym_valid(sv1), .sym_code(code1), .seq_pos(pos1), .seq_error(err1), .msg_done(done1)
  );

  typedef struct {
    logic [6:0] seg;
    logic [3:0] code;
  } enc_vec_t;

  typedef struct {
    logic [6:0] cur;
    int         run;
    logic [6:0] last;
    bit         sv;
    logic [3:0] code;
    bit         lock;
    int         pos;
    bit         err;
    bit         done;
  } mdl_t;

  enc_vec_t   enc_tab[11];
  logic [6:0] msg_pat[10];
  int         msg_code[10];
  mdl_t       m4, m1;
  int         n_vec = 0;
  int         n_err = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] enc(input logic [6:0] seg);
    for (int i = 0; i < 11; i++) if (enc_tab[i].seg == seg) return enc_tab[i].code;
    return 4'd14;
  endfunction

  // Behavioural reference: run length of the current value plus message position.
  function automatic mdl_t mstep(input mdl_t m, input logic [6:0] seg, input logic en,
                                 input logic rstn, input int s);
    mdl_t n = m;
    int   c;
    if (!rstn) begin
      n.cur = 7'd0; n.run = s; n.last = 7'd0; n.sv = 0; n.code = 4'd15;
      n.lock = 0; n.pos = 0; n.err = 0; n.done = 0;
      return n;
    end
    n.sv = 0;
    n.done = 0;
    if (!en) return n;
    if (seg == m.cur) n.run = m.run + 1;
    else begin
      n.cur = seg;
      n.run = 1;
    end
    if (n.run == s && n.cur != n.last) begin
      n.last = n.cur;
      n.sv   = 1;
      n.code = enc(n.cur);
      c = int'(n.code);
      if (!n.lock) begin
        if (c == 0) begin n.lock = 1; n.pos = 1; end
      end else if (c == 15) begin
        n.pos = n.pos;
      end else if (c == msg_code[n.pos]) begin
        n.pos  = (n.pos + 1) % 10;
        n.done = (n.pos == 0);
      end else begin
        n.err = 1;
        if (c == 0) n.pos = 1;
        else begin n.lock = 0; n.pos = 0; end
      end
    end
    return n;
  endfunction

  function automatic logic [10:0] exp_of(input mdl_t m);
    return {m.sv, m.code, SEQ_EN ? 4'(m.pos) : 4'd0, SEQ_EN ? m.err : 1'b0, SEQ_EN ? m.done : 1'b0};
  endfunction

  task automatic step(input logic [6:0] seg, input logic en, input logic rstn);
    segments = seg;
    ena      = en;
    rst_n    = rstn;
    @(posedge clk);
    m4 = mstep(m4, seg, en, rstn, 4);
    m1 = mstep(m1, seg, en, rstn, 1);
    #1;
    cmp("model_s4", 32'({sv4, code4, pos4, err4, done4}), 32'(exp_of(m4)));
    cmp("model_s1", 32'({sv1, code1, pos1, err1, done1}), 32'(exp_of(m1)));
  endtask

  task automatic hold(input logic [6:0] seg, input int n);
    for (int i = 0; i < n; i++) step(seg, 1'b1, 1'b1);
  endtask

  task automatic do_reset();
    step(7'd0, 1'b1, 1'b0);
    step(7'd0, 1'b1, 1'b0);
  endtask

  initial begin
    int         pulses, dones, dones_on_t;
    logic [3:0] got[$];
    logic [6:0] seg;

    enc_tab[0]  = '{7'b0111110, 4'd0};
    enc_tab[1]  = '{7'b1110111, 4'd1};
    enc_tab[2]  = '{7'b1111100, 4'd2};
    enc_tab[3]  = '{7'b0111001, 4'd3};
    enc_tab[4]  = '{7'b1000000, 4'd4};
    enc_tab[5]  = '{7'b1111001, 4'd5};
    enc_tab[6]  = '{7'b0111000, 4'd6};
    enc_tab[7]  = '{7'b0110001, 4'd9};
    enc_tab[8]  = '{7'b0000000, 4'd15};
    enc_tab[9]  = '{7'b1010101, 4'd14};
    enc_tab[10] = '{7'b1111111, 4'd14};
    msg_pat  = '{7'b0111110, 7'b1110111, 7'b1111100, 7'b0111001, 7'b1000000,
                 7'b1111001, 7'b0111000, 7'b1111001, 7'b0111001, 7'b0110001};
    msg_code = '{0, 1, 2, 3, 4, 5, 6, 5, 3, 9};
    m4 = '{default: 0};
    m1 = '{default: 0};

    // Reset values; a blank held across reset is never accepted.
    do_reset();
    cmp("reset_state", 32'({sv4, code4, pos4, err4, done4}), 32'({1'b0, 4'hF, 4'h0, 1'b0, 1'b0}));
    pulses = 0;
    for (int i = 0; i < 6; i++) begin hold(7'd0, 1); pulses += int'(sv4) + int'(sv1); end
    cmp("blank_after_reset", 32'(pulses), 32'd0);

    // Encoder table.
    for (int i = 0; i < 11; i++) begin
      hold((enc_tab[i].seg == 7'h7F) ? 7'h00 : 7'h7F, 6);
      hold(enc_tab[i].seg, 6);
      cmp("encode_tab", 32'(code4), 32'(enc_tab[i].code));
    end

    // Full message.
    do_reset();
    got = {};
    dones = 0;
    dones_on_t = 0;
    for (int i = 0; i < 10; i++) begin
      for (int j = 0; j < 6; j++) begin
        hold(msg_pat[i], 1);
        if (sv4) got.push_back(code4);
        if (done4) dones++;
        if (done4 && sv4 && code4 == 4'd9) dones_on_t++;
      end
    end
    cmp("msg_pulses", 32'(got.size()), 32'd10);
    for (int i = 0; i < 10 && i < got.size(); i++) cmp("msg_code", 32'(got[i]), 32'(msg_code[i]));
    cmp("msg_done_count", 32'(dones), SEQ_EN ? 32'd1 : 32'd0);
    cmp("msg_done_on_t", 32'(dones_on_t), SEQ_EN ? 32'd1 : 32'd0);
    cmp("msg_end_pos_err", 32'({pos4, err4}), 32'd0);

    // Glitch shorter than the filter window, then a full-length hold.
    do_reset();
    hold(msg_pat[0], 6);
    pulses = 0;
    for (int i = 0; i < 3; i++) begin hold(msg_pat[1], 1); pulses += int'(sv4); end
    for (int i = 0; i < 3; i++) begin hold(msg_pat[0], 1); pulses += int'(sv4); end
    cmp("glitch_no_accept", 32'(pulses), 32'd0);
    hold(msg_pat[1], 3);
    cmp("latency_edge_k2", 32'(sv4), 32'd0);
    hold(msg_pat[1], 1);
    cmp("latency_edge_k3", 32'({sv4, code4}), 32'({1'b1, 4'd1}));

    // Mismatch recovery.
    do_reset();
    hold(msg_pat[0], 6);
    hold(msg_pat[1], 6);
    hold(msg_pat[3], 6);
    cmp("mismatch_err_pos", 32'({err4, pos4}), SEQ_EN ? 32'({1'b1, 4'd0}) : 32'd0);
    hold(msg_pat[0], 6);
    cmp("resync_u", 32'({err4, pos4}), SEQ_EN ? 32'({1'b1, 4'd1}) : 32'd0);

    // Invalid pattern in LOCK.
    do_reset();
    hold(msg_pat[0], 6);
    hold(7'b1010101, 6);
    cmp("invalid_code_err", 32'({code4, err4}), 32'({4'd14, SEQ_EN}));

    // Blank between two E's.
    do_reset();
    for (int i = 0; i < 5; i++) hold(msg_pat[i], 6);
    got = {};
    for (int j = 0; j < 6; j++) begin hold(msg_pat[5], 1); if (sv4) got.push_back(code4); end
    for (int j = 0; j < 6; j++) begin hold(7'd0, 1); if (sv4) got.push_back(code4); end
    cmp("blank_keeps_pos", 32'(pos4), SEQ_EN ? 32'd6 : 32'd0);
    for (int j = 0; j < 6; j++) begin hold(msg_pat[5], 1); if (sv4) got.push_back(code4); end
    cmp("e_blank_e_pulses", 32'(got.size()), 32'd3);
    if (got.size() == 3) cmp("e_blank_e_codes", 32'({got[0], got[1], got[2]}), 32'h5F5);

    // Enable low freezes the count mid-window.
    do_reset();
    hold(msg_pat[0], 6);
    hold(msg_pat[1], 2);
    pulses = 0;
    for (int i = 0; i < 5; i++) begin step(msg_pat[2], 1'b0, 1'b1); pulses += int'(sv4) + int'(sv1); end
    cmp("ena_low_no_accept", 32'(pulses), 32'd0);
    hold(msg_pat[1], 1);
    cmp("ena_resume_1", 32'(sv4), 32'd0);
    hold(msg_pat[1], 1);
    cmp("ena_resume_2", 32'({sv4, code4}), 32'({1'b1, 4'd1}));

    // Reset mid-message with enable low.
    do_reset();
    for (int i = 0; i < 6; i++) hold(msg_pat[i], 6);
    cmp("pre_reset_pos", 32'(pos4), SEQ_EN ? 32'd6 : 32'd0);
    step(msg_pat[5], 1'b0, 1'b0);
    cmp("mid_reset", 32'({sv4, code4, pos4, err4, done4}), 32'({1'b0, 4'hF, 4'h0, 1'b0, 1'b0}));
    hold(msg_pat[5], 6);

    // Randomised traffic, biased toward the next expected symbol.
    for (int b = 0; b < 400; b++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: seg = msg_pat[m4.pos];
        4, 5:       seg = msg_pat[$urandom_range(0, 9)];
        6:          seg = 7'd0;
        7:          seg = 7'($urandom);
        default:    seg = msg_pat[m1.pos];
      endcase
      for (int i = $urandom_range(1, 7); i > 0; i--)
        step(seg, 1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 199) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
